// File: rtl/bp_me_io_cmd_arbiter.sv
// Round-robin sharing of one single-beat BedRock I/O command/response port among
// several clients; grant order is kept in a FIFO so in-order responses go back to their issuer.
//
// state   | meaning
// ST_OPEN | free to arbitrate; sel follows the round-robin search
// ST_LOCK | a presented command stalled; its client stays selected until handshake
module bp_me_io_cmd_arbiter #(
  parameter int num_clients_p     = 2,
  parameter int header_width_p    = 64,
  parameter int data_width_p      = 32,
  parameter int num_outstanding_p = 8
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic [num_clients_p*header_width_p-1:0] cli_cmd_header_i,
  input  logic [num_clients_p*data_width_p-1:0]   cli_cmd_data_i,
  input  logic [num_clients_p-1:0]                cli_cmd_v_i,
  output logic [num_clients_p-1:0]                cli_cmd_ready_and_o,
  output logic [header_width_p-1:0]               cli_resp_header_o,
  output logic [data_width_p-1:0]                 cli_resp_data_o,
  output logic [num_clients_p-1:0]                cli_resp_v_o,
  input  logic [num_clients_p-1:0]                cli_resp_ready_and_i,
  output logic [header_width_p-1:0]               io_cmd_header_o,
  output logic [data_width_p-1:0]                 io_cmd_data_o,
  output logic                                    io_cmd_v_o,
  output logic                                    io_cmd_last_o,
  input  logic                                    io_cmd_ready_and_i,
  input  logic [header_width_p-1:0]               io_resp_header_i,
  input  logic [data_width_p-1:0]                 io_resp_data_i,
  input  logic                                    io_resp_v_i,
  input  logic                                    io_resp_last_i,
  output logic                                    io_resp_ready_and_o
);

  localparam int id_w_lp  = (num_clients_p > 1) ? $clog2(num_clients_p) : 1;
  localparam int ptr_w_lp = (num_outstanding_p > 1) ? $clog2(num_outstanding_p) : 1;
  localparam int cnt_w_lp = $clog2(num_outstanding_p + 1);

  typedef enum logic {ST_OPEN = 1'b0, ST_LOCK = 1'b1} state_e;

  state_e               r_state, w_state_nxt;
  logic [id_w_lp-1:0]   r_rr_ptr, r_sel, w_rr_sel, w_sel, w_head;
  logic [cnt_w_lp-1:0]  r_count;
  logic [ptr_w_lp-1:0]  r_wr_ptr, r_rd_ptr;
  logic [id_w_lp-1:0]   r_fifo [num_outstanding_p];
  logic                 w_rr_found, w_can_issue, w_empty, w_cmd_hs, w_resp_hs;
  logic                 w_unused;

  assign w_unused = io_resp_last_i;

  always_comb begin
    logic [id_w_lp-1:0] idx;
    idx        = '0;
    w_rr_sel   = r_rr_ptr;
    w_rr_found = 1'b0;
    for (int i = 0; i < num_clients_p; i++) begin
      idx = id_w_lp'((int'(r_rr_ptr) + i) % num_clients_p);
      if (!w_rr_found && cli_cmd_v_i[idx]) begin
        w_rr_sel   = idx;
        w_rr_found = 1'b1;
      end
    end
  end

  assign w_sel       = (r_state == ST_LOCK) ? r_sel : w_rr_sel;
  assign w_empty     = (r_count == '0);
  assign w_can_issue = (r_count < cnt_w_lp'(num_outstanding_p));
  assign w_head      = r_fifo[r_rd_ptr];

  // reset_n_i gates the handshake outputs so they drop the instant reset asserts
  assign io_cmd_v_o      = reset_n_i & w_can_issue & cli_cmd_v_i[w_sel];
  assign io_cmd_last_o   = io_cmd_v_o;
  assign io_cmd_header_o = cli_cmd_header_i[int'(w_sel)*header_width_p +: header_width_p];
  assign io_cmd_data_o   = cli_cmd_data_i[int'(w_sel)*data_width_p +: data_width_p];
  assign w_cmd_hs        = io_cmd_v_o & io_cmd_ready_and_i;

  always_comb begin
    cli_cmd_ready_and_o = '0;
    if (reset_n_i) cli_cmd_ready_and_o[w_sel] = io_cmd_ready_and_i & w_can_issue;
  end

  assign io_resp_ready_and_o = reset_n_i & ~w_empty & cli_resp_ready_and_i[w_head];
  assign cli_resp_header_o   = io_resp_header_i;
  assign cli_resp_data_o     = io_resp_data_i;
  assign w_resp_hs           = io_resp_v_i & io_resp_ready_and_o;

  always_comb begin
    cli_resp_v_o = '0;
    if (reset_n_i && io_resp_v_i && !w_empty) cli_resp_v_o[w_head] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OPEN: if (io_cmd_v_o && !io_cmd_ready_and_i) w_state_nxt = ST_LOCK;
      ST_LOCK: if (w_cmd_hs) w_state_nxt = ST_OPEN;
      default: w_state_nxt = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= ST_OPEN;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_OPEN && w_state_nxt == ST_LOCK) r_sel <= w_rr_sel;
      if (w_cmd_hs) begin
        r_rr_ptr <= (int'(w_sel) == num_clients_p - 1) ? '0 : w_sel + 1'b1;
        r_wr_ptr <= (int'(r_wr_ptr) == num_outstanding_p - 1) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_resp_hs)
        r_rd_ptr <= (int'(r_rd_ptr) == num_outstanding_p - 1) ? '0 : r_rd_ptr + 1'b1;
      if (w_cmd_hs && !w_resp_hs)      r_count <= r_count + 1'b1;
      else if (!w_cmd_hs && w_resp_hs) r_count <= r_count - 1'b1;
    end
  end

  // Slot contents need no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk_i) begin
    if (w_cmd_hs) r_fifo[r_wr_ptr] <= w_sel;
  end

  a_resp_when_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(io_resp_v_i && w_empty));

  a_hold_valid_locked: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (r_state == ST_LOCK) |-> cli_cmd_v_i[r_sel]);

endmodule
